// File: rtl/cordic_phase_sequencer.sv
// NCO phase accumulator and quadrant folding in front of cordic_sincos.
// Launches one CORDIC run per sample and sign-corrects the returned pair.
module cordic_phase_sequencer #(
    parameter int          TIMEOUT   = 64,
    parameter logic [31:0] PI_OVER_2 = 32'h6487ED51
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] freq_word,
    input  logic        phase_clr,
    output logic [31:0] cordic_theta,
    output logic        cordic_start,
    input  logic [31:0] cordic_sin,
    input  logic [31:0] cordic_cos,
    input  logic        cordic_done,
    output logic [31:0] sin_out,
    output logic [31:0] cos_out,
    output logic        out_valid,
    output logic        busy,
    output logic        timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    phase_q, phase_d;
    logic [31:0]    theta_q, theta_d;
    logic           flip_q, flip_d;
    logic [31:0]    sin_q, sin_d;
    logic [31:0]    cos_q, cos_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [31:0]        s_fold;
    logic               flip_n;
    logic signed [63:0] prod;

    function automatic logic [31:0] neg_sat(input logic [31:0] x);
        return (x == 32'h8000_0000) ? 32'h7FFF_FFFF : (~x + 32'd1);
    endfunction

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        theta_d = theta_q;
        flip_d  = flip_q;
        sin_d   = sin_q;
        cos_d   = cos_q;
        valid_d = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;

        // Quadrants 1 and 2 are shifted by half a turn; the sign flip undoes it.
        flip_n = (phase_q[31] != phase_q[30]);
        s_fold = flip_n ? (phase_q ^ 32'h8000_0000) : phase_q;
        prod   = $signed({{32{s_fold[31]}}, s_fold})
               * $signed({32'b0, PI_OVER_2});

        unique case (state_q)
            S_IDLE: begin
                if (en) state_d = S_PREP;
            end
            S_PREP: begin
                phase_d = phase_q + freq_word;
                theta_d = 32'(prod >>> 30);
                flip_d  = flip_n;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cordic_done) begin
                    sin_d   = flip_q ? neg_sat(cordic_sin) : cordic_sin;
                    cos_d   = flip_q ? neg_sat(cordic_cos) : cordic_cos;
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (phase_clr) begin
            phase_d = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            theta_q <= '0;
            flip_q  <= 1'b0;
            sin_q   <= '0;
            cos_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            theta_q <= theta_d;
            flip_q  <= flip_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cordic_theta = theta_q;
    assign cordic_start = (state_q == S_ISSUE);
    assign sin_out      = sin_q;
    assign cos_out      = cos_q;
    assign out_valid    = valid_q;
    assign busy         = (state_q != S_IDLE);
    assign timeout_err  = err_q;

endmodule
